// File: rtl/wb_capture.sv
// wb_capture: FWFT capture queue for processor write-backs, with sticky overflow flag and drop counter.
// Latency: an entry written at edge N is presented on out_data (and out_ts under WBCAP_TS_EN) after edge N.
// Backpressure: none towards the producer; writes into a full queue are dropped unless a pop frees a slot that cycle.
module wb_capture #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int DCW   = 8,
`ifdef WBCAP_TS_EN
    parameter int TSW   = 16,
`endif
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [W-1:0]  wd,
    input  logic          clr,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    input  logic          out_ready,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic [DCW-1:0] drop_cnt
`ifdef WBCAP_TS_EN
    ,
    output logic [TSW-1:0] out_ts
`endif
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push;
    logic          pop;
    logic          drop;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr];

    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign pop  = out_valid & out_ready;
    assign push = we & (!full | pop);
    assign drop = we & full & !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (clr) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + DCW'(1);
            end
        end
    end

    // Storage is deliberately left unreset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr] <= wd;
    end

`ifdef WBCAP_TS_EN
    logic [TSW-1:0] ts_cnt;
    logic [TSW-1:0] ts_mem [DEPTH];

    assign out_ts = ts_mem[rd_ptr];

    // Free-running cycle counter; clr leaves it alone so timestamps stay monotonic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ts_cnt <= '0;
        else      ts_cnt <= ts_cnt + TSW'(1);
    end

    always_ff @(posedge clk) begin
        if (push && !clr) ts_mem[wr_ptr] <= ts_cnt;
    end
`endif

endmodule
